// File: rtl/sine_pwm_pkg.sv
// Shared definitions for sine_pwm_nch: step count, normalised 36-entry sine table,
// channel phase-offset and table rescaling helpers.
package sine_pwm_pkg;

    localparam int STEPS  = 36;
    localparam int NORM_W = 17;

    // Entries are round(65536*(0.5+0.5*sin(2*pi*i/36))), rescaled to R bits by sine_scale.
    function automatic logic [NORM_W-1:0] sine_norm(input logic [5:0] idx);
        logic [NORM_W-1:0] v;
        case (idx)
            6'd0:    v = 17'd32768;
            6'd1:    v = 17'd38458;
            6'd2:    v = 17'd43975;
            6'd3:    v = 17'd49152;
            6'd4:    v = 17'd53831;
            6'd5:    v = 17'd57870;
            6'd6:    v = 17'd61146;
            6'd7:    v = 17'd63560;
            6'd8:    v = 17'd65038;
            6'd9:    v = 17'd65536;
            6'd10:   v = 17'd65038;
            6'd11:   v = 17'd63560;
            6'd12:   v = 17'd61146;
            6'd13:   v = 17'd57870;
            6'd14:   v = 17'd53831;
            6'd15:   v = 17'd49152;
            6'd16:   v = 17'd43975;
            6'd17:   v = 17'd38458;
            6'd18:   v = 17'd32768;
            6'd19:   v = 17'd27078;
            6'd20:   v = 17'd21561;
            6'd21:   v = 17'd16384;
            6'd22:   v = 17'd11705;
            6'd23:   v = 17'd7666;
            6'd24:   v = 17'd4390;
            6'd25:   v = 17'd1976;
            6'd26:   v = 17'd498;
            6'd27:   v = 17'd0;
            6'd28:   v = 17'd498;
            6'd29:   v = 17'd1976;
            6'd30:   v = 17'd4390;
            6'd31:   v = 17'd7666;
            6'd32:   v = 17'd11705;
            6'd33:   v = 17'd16384;
            6'd34:   v = 17'd21561;
            6'd35:   v = 17'd27078;
            default: v = 17'd32768;
        endcase
        return v;
    endfunction

    function automatic int unsigned ch_offset(input int unsigned k, input int unsigned ch);
        return (k * 32'(STEPS)) / ch;
    endfunction

    // Round-half-up rescale to r bits, clamped so the crest fits in the counter range.
    function automatic int unsigned sine_scale(input logic [NORM_W-1:0] norm, input int unsigned r);
        int unsigned v;
        int unsigned vmax;
        v    = ((32'(norm) << r) + 32'd32768) >> 16;
        vmax = (32'd1 << r) - 32'd1;
        return (v > vmax) ? vmax : v;
    endfunction

endpackage

// File: rtl/sine_pwm_nch_lut.sv
// sine_lut: combinational R-bit sine ROM, one instance per output channel.
module sine_lut
    import sine_pwm_pkg::*;
#(
    parameter int R = 6
) (
    input  logic [5:0]   i_idx,
    output logic [R-1:0] o_duty
);

    always_comb begin
        o_duty = R'(sine_scale(sine_norm(i_idx), R));
    end

endmodule

// File: rtl/sine_pwm_nch.sv
// Multi-channel sine PWM generator with phase-shifted channels and shadowed step rate.
// Optional complementary outputs with dead time under macro SINE_PWM_DEADTIME_EN.
module sine_pwm_nch
    import sine_pwm_pkg::*;
#(
    parameter int R     = 6,
    parameter int CH    = 3,
    parameter int STEPS = 36,
    parameter int DT    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [11:0]   n_in,
    output logic [CH-1:0] pwm_out,
`ifdef SINE_PWM_DEADTIME_EN
    output logic [CH-1:0] pwm_out_n,
`endif
    output logic [5:0]    step,
    output logic          step_tick
);

    localparam logic [R-1:0] CNT_MAX  = {R{1'b1}};
    localparam logic [R-1:0] CNT_ONE  = R'(1);
    localparam logic [5:0]   STEP_MAX = 6'(STEPS - 1);

    logic [R-1:0]  r_cnt;
    logic [11:0]   r_n;
    logic [11:0]   r_nsh;
    logic          r_nsh_vld;
    logic [5:0]    r_step;
    logic          r_tick;
    logic          w_eop;
    logic          w_adv;
    logic [11:0]   w_n_sh;
    logic [11:0]   w_n_lim;
    logic [5:0]    w_step_nxt;
    logic [CH-1:0] w_des;

    // Configurations outside the supported range elaborate no extra hardware.
    if (CH < 1 || CH > 6 || DT < 0) begin : g_cfg_out_of_range
    end

    always_comb begin
        w_eop   = (r_cnt == CNT_MAX);
        w_n_sh  = r_nsh_vld ? r_nsh : n_in;
        w_n_lim = (w_n_sh == 12'd0) ? 12'd1 : w_n_sh;
        w_adv   = en && w_eop && (r_n == (w_n_lim - 12'd1));
        if (w_adv) begin
            w_step_nxt = (r_step == STEP_MAX) ? 6'd0 : r_step + 6'd1;
        end else begin
            w_step_nxt = r_step;
        end
    end

    // N_sh is taken from n_in on the first edge after reset and then only at step advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_n       <= 12'd0;
            r_nsh     <= 12'd0;
            r_nsh_vld <= 1'b0;
            r_step    <= 6'd0;
            r_tick    <= 1'b0;
        end else begin
            r_nsh_vld <= 1'b1;
            if (!r_nsh_vld || w_adv) begin
                r_nsh <= n_in;
            end
            if (en) begin
                r_cnt <= r_cnt + CNT_ONE;
                r_n   <= w_adv ? 12'd0 : (w_eop ? r_n + 12'd1 : r_n);
            end else begin
                r_cnt <= '0;
                r_n   <= 12'd0;
            end
            r_step <= w_step_nxt;
            r_tick <= w_adv;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        localparam logic [5:0]   OFF      = 6'(ch_offset(k, CH));
        localparam logic [R-1:0] DUTY_RST = R'(sine_scale(sine_norm(OFF), R));

        logic [6:0]   w_sum;
        logic [5:0]   w_idx;
        logic [R-1:0] w_lut;
        logic [R-1:0] r_duty;

        // Index follows the post-advance step so the new duty lands exactly at cnt==0.
        assign w_sum = {1'b0, w_step_nxt} + {1'b0, OFF};
        assign w_idx = (w_sum >= 7'(STEPS)) ? 6'(w_sum - 7'(STEPS)) : w_sum[5:0];

        sine_lut #(.R(R)) u_lut (
            .i_idx  (w_idx),
            .o_duty (w_lut)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_duty <= DUTY_RST;
            end else if (en && w_eop) begin
                r_duty <= w_lut;
            end
        end

        assign w_des[k] = en && (r_cnt < r_duty);
    end

`ifdef SINE_PWM_DEADTIME_EN
    localparam logic [7:0] DT_LOAD = (DT > 0) ? 8'(DT - 1) : 8'd0;

    logic [CH-1:0] r_last;
    logic [CH-1:0] r_hi;
    logic [CH-1:0] r_lo;
    logic [7:0]    r_dt [CH];

    // Any change of the wanted level blanks both outputs for DT cycles before the new side drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            for (int k = 0; k < CH; k++) begin
                r_dt[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (!en) begin
                    r_last[k] <= 1'b0;
                    r_dt[k]   <= 8'd0;
                    r_hi[k]   <= 1'b0;
                    r_lo[k]   <= 1'b0;
                end else if (w_des[k] != r_last[k]) begin
                    r_last[k] <= w_des[k];
                    r_dt[k]   <= DT_LOAD;
                    r_hi[k]   <= 1'b0;
                    r_lo[k]   <= 1'b0;
                end else if (r_dt[k] != 8'd0) begin
                    r_dt[k]   <= r_dt[k] - 8'd1;
                    r_hi[k]   <= 1'b0;
                    r_lo[k]   <= 1'b0;
                end else begin
                    r_hi[k]   <= r_last[k];
                    r_lo[k]   <= ~r_last[k];
                end
            end
        end
    end

    assign pwm_out   = r_hi;
    assign pwm_out_n = r_lo;
`else
    logic [CH-1:0] r_pwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= w_des;
        end
    end

    assign pwm_out = r_pwm;
`endif

    assign step      = r_step;
    assign step_tick = r_tick;

endmodule

// File: tb/tb_sine_pwm_nch.sv
// Randomised self-checking bench for sine_pwm_nch against a period/step level reference model.
module tb_sine_pwm_nch;

    localparam int R  = 6;
    localparam int CH = 3;
    localparam int DT = 2;
    localparam int PERIOD = 1 << R;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [11:0]   n_in;
    logic [CH-1:0] pwm_out;
`ifdef SINE_PWM_DEADTIME_EN
    logic [CH-1:0] pwm_out_n;
`endif
    logic [5:0]    step;
    logic          step_tick;

    always #5 clk = ~clk;

    sine_pwm_nch #(.R(R), .CH(CH), .STEPS(36), .DT(DT)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .n_in      (n_in),
        .pwm_out   (pwm_out),
`ifdef SINE_PWM_DEADTIME_EN
        .pwm_out_n (pwm_out_n),
`endif
        .step      (step),
        .step_tick (step_tick)
    );

    int n_total = 0;
    int n_bad   = 0;

    int tbl [36];
    int off [CH];
    int m_cnt, m_per, m_step, m_N;
    int m_duty [CH];
    bit m_nload;
    int hc [CH];
    bit first_done;
    int tick_cnt;

`ifdef SINE_PWM_DEADTIME_EN
    bit            track_gap;
    logic [CH-1:0] prev_hi, prev_lo;
    int            since_fall [CH];
    bit            seen_fall [CH];
    bit            last_fall_hi [CH];
`endif

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_per   = 0;
        m_step  = 0;
        m_N     = 1;
        m_nload = 1'b1;
        for (int k = 0; k < CH; k++) begin
            m_duty[k] = tbl[off[k]];
            hc[k]     = 0;
        end
    endtask

    // One clock: predict, advance the model at the edge, compare on the falling edge.
    task automatic clk_step();
        logic [CH-1:0] exp_pwm;
        bit            exp_tick;
        bit            pre_en;
        int            pre_cnt;
        int            pre_step;
        pre_en   = en;
        pre_cnt  = m_cnt;
        pre_step = m_step;
        for (int k = 0; k < CH; k++) begin
            exp_pwm[k] = pre_en && (m_cnt < m_duty[k]);
        end
        @(posedge clk);
        exp_tick = 1'b0;
        if (m_nload) begin
            m_N     = (n_in == 12'd0) ? 1 : int'(n_in);
            m_nload = 1'b0;
        end
        if (pre_en) begin
            if (m_cnt == PERIOD - 1) begin
                m_per++;
                if (m_per >= m_N) begin
                    m_per    = 0;
                    m_step   = (m_step + 1) % 36;
                    m_N      = (n_in == 12'd0) ? 1 : int'(n_in);
                    exp_tick = 1'b1;
                end
                for (int k = 0; k < CH; k++) begin
                    m_duty[k] = tbl[(m_step + off[k]) % 36];
                end
            end
            m_cnt = (m_cnt + 1) % PERIOD;
        end else begin
            m_cnt = 0;
            m_per = 0;
        end
        @(negedge clk);
        check_eq("step", 32'(step), m_step);
        check_eq("step_tick", 32'(step_tick), 32'(exp_tick));
        if (step_tick === 1'b1) tick_cnt++;
`ifndef SINE_PWM_DEADTIME_EN
        check_eq("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        if (pre_en) begin
            for (int k = 0; k < CH; k++) begin
                if (pre_cnt == 0) hc[k] = 0;
                hc[k] += int'(pwm_out[k]);
            end
            if (pre_cnt == PERIOD - 1) begin
                if (!first_done) begin
                    check_eq("first_period_ch0", hc[0], 32);
                    check_eq("first_period_ch1", hc[1], 60);
                    check_eq("first_period_ch2", hc[2], 4);
                    first_done = 1'b1;
                end
                if (pre_step == 9)  check_eq("ch0_high_step9", hc[0], 63);
                if (pre_step == 27) check_eq("ch0_high_step27", hc[0], 0);
            end
        end
`else
        check_eq("dt_overlap", 32'(pwm_out & pwm_out_n), 0);
        if (track_gap) begin
            for (int k = 0; k < CH; k++) begin
                since_fall[k]++;
                if (prev_hi[k] && !pwm_out[k]) begin
                    since_fall[k] = 0; seen_fall[k] = 1'b1; last_fall_hi[k] = 1'b1;
                end
                if (prev_lo[k] && !pwm_out_n[k]) begin
                    since_fall[k] = 0; seen_fall[k] = 1'b1; last_fall_hi[k] = 1'b0;
                end
                if (!prev_hi[k] && pwm_out[k] && seen_fall[k] && !last_fall_hi[k])
                    check_eq("dt_gap_hi", since_fall[k], DT);
                if (!prev_lo[k] && pwm_out_n[k] && seen_fall[k] && last_fall_hi[k])
                    check_eq("dt_gap_lo", since_fall[k], DT);
            end
        end
        prev_hi = pwm_out;
        prev_lo = pwm_out_n;
`endif
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            clk_step();
            cycles++;
        end while (step_tick !== 1'b1 && cycles < 2000);
    endtask

    initial begin
        int  c;
        int  guard;
        real x;
        for (int i = 0; i < 36; i++) begin
            x = real'(PERIOD) * (0.5 + 0.5 * $sin(2.0 * 3.14159265358979 * real'(i) / 36.0));
            tbl[i] = $rtoi($floor(x + 0.5));
            if (tbl[i] > PERIOD - 1) tbl[i] = PERIOD - 1;
            if (tbl[i] < 0) tbl[i] = 0;
        end
        for (int k = 0; k < CH; k++) off[k] = (k * 36) / CH;
`ifdef SINE_PWM_DEADTIME_EN
        track_gap = 1'b0;
        prev_hi   = '0;
        prev_lo   = '0;
        for (int k = 0; k < CH; k++) begin
            since_fall[k] = 0; seen_fall[k] = 1'b0; last_fall_hi[k] = 1'b0;
        end
`endif

        rst  = 1'b1;
        en   = 1'b0;
        n_in = 12'd1;
        #12;
        check_eq("rst_pwm", 32'(pwm_out), 0);
        check_eq("rst_step", 32'(step), 0);
        check_eq("rst_tick", 32'(step_tick), 0);
        @(negedge clk);
        model_reset();
        first_done = 1'b0;
        rst = 1'b0;
        en  = 1'b1;

        // Full electrical cycle at one period per step.
        tick_cnt = 0;
`ifdef SINE_PWM_DEADTIME_EN
        track_gap = 1'b1;
`endif
        repeat (36 * PERIOD) clk_step();
        check_eq("ticks_per_cycle", tick_cnt, 36);
        check_eq("step_wrapped", 32'(step), 0);
`ifdef SINE_PWM_DEADTIME_EN
        track_gap = 1'b0;
`endif

        // Rate change mid-step only applies from the following step.
        n_in = 12'd3;
        wait_tick(c);
        c = 0;
        do begin
            clk_step();
            c++;
            if (c == PERIOD) n_in = 12'd5;
        end while (step_tick !== 1'b1 && c < 2000);
        check_eq("step_len_n3", c, 3 * PERIOD);
        wait_tick(c);
        check_eq("step_len_n5", c, 5 * PERIOD);

        // Pause at cnt 40 of step 7, then resume.
        n_in  = 12'd1;
        guard = 0;
        while (!(m_step == 7 && m_cnt == 40) && guard < 6000) begin
            clk_step();
            guard++;
        end
        check_eq("reach_step7", 32'(guard < 6000), 1);
        en = 1'b0;
        clk_step();
        check_eq("pause_pwm", 32'(pwm_out), 0);
        check_eq("pause_step", 32'(step), 7);
        repeat (10) clk_step();
        en = 1'b1;
        clk_step();
`ifndef SINE_PWM_DEADTIME_EN
        check_eq("resume_pwm", 32'(pwm_out), 32'b111);
`endif
        repeat (2 * PERIOD) clk_step();

        // Random rate and enable activity.
        repeat (4000) begin
            if (en) begin
                if ($urandom_range(0, 299) == 0) en = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) en = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) n_in = 12'($urandom_range(0, 3));
            clk_step();
        end

        // Asynchronous reset between clock edges.
        en   = 1'b1;
        n_in = 12'd1;
        repeat (PERIOD + 17) clk_step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_pwm", 32'(pwm_out), 0);
        check_eq("arst_step", 32'(step), 0);
        check_eq("arst_tick", 32'(step_tick), 0);
`ifdef SINE_PWM_DEADTIME_EN
        check_eq("arst_pwm_n", 32'(pwm_out_n), 0);
`endif
        #1;
        rst = 1'b0;
        model_reset();
        first_done = 1'b0;
        repeat (2 * PERIOD + 5) clk_step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
